// File: rtl/uart_tx_arbiter.sv
// uart_tx_arbiter: round-robin arbiter that shares one UART TX FIFO among
// NUM_REQ requesters. A grant is held for a whole message (up to and including
// the byte flagged last), so messages never interleave on the serial line.
// Optional build macro: UART_TX_ARB_TIMEOUT_EN adds a watchdog that revokes a
// grant whose owner has stopped presenting bytes for TIMEOUT_CYCLES cycles.
module uart_tx_arbiter #(
  parameter int NUM_REQ        = 4,
  parameter int TIMEOUT_CYCLES = 1024
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [NUM_REQ-1:0]   req_valid,
  input  logic [8*NUM_REQ-1:0] req_data,
  input  logic [NUM_REQ-1:0]   req_last,
  output logic [NUM_REQ-1:0]   req_ready,
  output logic [7:0]           transmit_data,
  output logic                 buffer_write,
  input  logic                 transmit_full,
  output logic [NUM_REQ-1:0]   grant,
  output logic                 busy,
  output logic                 timeout_err
);

  localparam int PTR_W = $clog2(NUM_REQ);

  if (NUM_REQ < 2 || NUM_REQ > 8 || TIMEOUT_CYCLES < 1) begin : g_param_check
    $error("uart_tx_arbiter: parameter out of range");
  end

  typedef enum logic {
    IDLE = 1'b0,
    SEND = 1'b1
  } state_t;

  state_t             state;
  state_t             next_state;
  logic [PTR_W-1:0]   last_grant;
  logic [PTR_W-1:0]   next_last_grant;
  logic [PTR_W-1:0]   owner;
  logic [PTR_W-1:0]   next_owner;
  logic [NUM_REQ-1:0] next_grant;
  logic               pick_found;
  logic [PTR_W-1:0]   pick_idx;
  logic [PTR_W-1:0]   cand;
  logic [7:0]         sel_data;
  logic               sel_last;
  logic               accept;
  logic               revoke;

  // Rotating priority scan: start one past the previous owner and wrap.
  always_comb begin
    pick_found = 1'b0;
    pick_idx   = '0;
    cand       = '0;
    for (int k = 1; k <= NUM_REQ; k++) begin
      cand = PTR_W'((int'(last_grant) + k) % NUM_REQ);
      if (!pick_found && req_valid[cand]) begin
        pick_found = 1'b1;
        pick_idx   = cand;
      end
    end
  end

  // Mux the owner's byte and last flag using the one-hot grant.
  always_comb begin
    sel_data = '0;
    sel_last = 1'b0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (grant[i]) begin
        sel_data = req_data[i*8 +: 8];
        sel_last = req_last[i];
      end
    end
  end

  // Handshake: only the owner may be accepted, and never right after a write
  // so the FIFO's lagging full flag has a cycle to catch up.
  always_comb begin
    req_ready = '0;
    if (state == SEND && !transmit_full && !buffer_write) begin
      req_ready = grant & req_valid;
    end
  end

  assign accept = |req_ready;
  assign busy   = (state == SEND);

  // Next-state logic: arbitrate in IDLE, release after the last byte or a revoke.
  always_comb begin
    next_state      = state;
    next_grant      = grant;
    next_owner      = owner;
    next_last_grant = last_grant;
    case (state)
      IDLE: begin
        if (pick_found) begin
          next_state = SEND;
          next_grant = NUM_REQ'(1) << pick_idx;
          next_owner = pick_idx;
        end
      end
      SEND: begin
        if ((accept && sel_last) || revoke) begin
          next_state      = IDLE;
          next_grant      = '0;
          next_last_grant = owner;
        end
      end
      default: begin
        next_state = IDLE;
        next_grant = '0;
      end
    endcase
  end

  // State, grant bookkeeping and the registered FIFO write port.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state         <= IDLE;
      grant         <= '0;
      owner         <= '0;
      last_grant    <= PTR_W'(NUM_REQ - 1);
      transmit_data <= 8'h00;
      buffer_write  <= 1'b0;
    end else begin
      state        <= next_state;
      grant        <= next_grant;
      owner        <= next_owner;
      last_grant   <= next_last_grant;
      buffer_write <= accept;
      if (accept) begin
        transmit_data <= sel_data;
      end
    end
  end

`ifdef UART_TX_ARB_TIMEOUT_EN
  localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);

  logic [CNT_W-1:0] idle_count;
  logic             owner_valid;

  assign owner_valid = |(grant & req_valid);
  assign revoke      = (state == SEND) && !owner_valid &&
                       (idle_count == CNT_W'(TIMEOUT_CYCLES - 1));

  // Count cycles the owner leaves its valid low; any accept restarts the count.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      idle_count  <= '0;
      timeout_err <= 1'b0;
    end else begin
      timeout_err <= revoke;
      if (state != SEND || accept || revoke) begin
        idle_count <= '0;
      end else if (!owner_valid) begin
        idle_count <= idle_count + CNT_W'(1);
      end
    end
  end
`else
  assign revoke      = 1'b0;
  assign timeout_err = 1'b0;
`endif

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Testbench for uart_tx_arbiter: requester queues feed the DUT through a
// handshake driver, and a scoreboard compares every FIFO write against the
// byte order each scenario predicts.
module tb_uart_tx_arbiter;

  localparam int NUM_REQ = 4;

  logic                 clk = 1'b0;
  logic                 reset = 1'b1;
  logic [NUM_REQ-1:0]   req_valid;
  logic [8*NUM_REQ-1:0] req_data;
  logic [NUM_REQ-1:0]   req_last;
  logic [NUM_REQ-1:0]   req_ready;
  logic [7:0]           transmit_data;
  logic                 buffer_write;
  logic                 transmit_full;
  logic [NUM_REQ-1:0]   grant;
  logic                 busy;
  logic                 timeout_err;

  int checks = 0;
  int passed = 0;

  // Pending bytes per requester ({last, data}) and expected FIFO byte order.
  logic [8:0] msg_q [NUM_REQ][$];
  logic [7:0] exp_q [$];

  uart_tx_arbiter #(
    .NUM_REQ        (NUM_REQ),
    .TIMEOUT_CYCLES (16)
  ) dut (
    .clk           (clk),
    .reset         (reset),
    .req_valid     (req_valid),
    .req_data      (req_data),
    .req_last      (req_last),
    .req_ready     (req_ready),
    .transmit_data (transmit_data),
    .buffer_write  (buffer_write),
    .transmit_full (transmit_full),
    .grant         (grant),
    .busy          (busy),
    .timeout_err   (timeout_err)
  );

  always #5 clk = ~clk;

  // Requester model: present the head of each queue, pop it once accepted.
  initial begin : driver
    logic [NUM_REQ-1:0] taken;
    logic [8:0]         head;
    req_valid = '0;
    req_data  = '0;
    req_last  = '0;
    taken     = '0;
    forever begin
      @(negedge clk);
      #3;
      taken = req_ready & req_valid;
      @(posedge clk);
      #1;
      for (int i = 0; i < NUM_REQ; i++) begin
        if (!reset && taken[i] && msg_q[i].size() > 0) begin
          void'(msg_q[i].pop_front());
        end
        if (msg_q[i].size() > 0) begin
          head               = msg_q[i][0];
          req_valid[i]       = 1'b1;
          req_data[8*i +: 8] = head[7:0];
          req_last[i]        = head[8];
        end else begin
          req_valid[i]       = 1'b0;
          req_data[8*i +: 8] = 8'h00;
          req_last[i]        = 1'b0;
        end
      end
    end
  end

  // Scoreboard: each FIFO write must match the next expected byte, never back to back.
  initial begin : monitor
    logic       prev_write;
    logic [7:0] exp_byte;
    prev_write = 1'b0;
    forever begin
      @(negedge clk);
      if (buffer_write === 1'b1) begin
        checks++;
        if (prev_write) begin
          $display("[TB] FAIL write_spacing: got writes on consecutive cycles, expected a gap");
        end else begin
          passed++;
        end
        checks++;
        if (exp_q.size() == 0) begin
          $display("[TB] FAIL unexpected_write: got 8'h%02h, expected no write", transmit_data);
        end else begin
          exp_byte = exp_q.pop_front();
          if (transmit_data !== exp_byte) begin
            $display("[TB] FAIL fifo_byte: got 8'h%02h, expected 8'h%02h", transmit_data, exp_byte);
          end else begin
            passed++;
          end
        end
      end
      prev_write = (buffer_write === 1'b1);
    end
  end

  initial begin : watchdog
    #200000;
    $display("[TB] FAIL watchdog: simulation ran past its time limit");
    $fatal(1, "[TB] watchdog expired");
  end

  function automatic bit all_idle();
    bit idle;
    idle = (exp_q.size() == 0) && (busy === 1'b0);
    for (int i = 0; i < NUM_REQ; i++) begin
      if (msg_q[i].size() != 0) idle = 1'b0;
    end
    return idle;
  endfunction

  task automatic wait_drain(input int budget, output bit ok);
    ok = 1'b0;
    for (int n = 0; n < budget; n++) begin
      @(negedge clk);
      if (all_idle()) begin
        ok = 1'b1;
        break;
      end
    end
    repeat (3) @(negedge clk);
  endtask

  task automatic wait_grant(input int budget);
    for (int n = 0; n < budget; n++) begin
      @(negedge clk);
      if (grant !== '0) break;
    end
  endtask

  task automatic test_reset();
    bit ok;
    @(posedge clk);
    #1;
    checks++;
    if ({req_ready, transmit_data, buffer_write, grant, busy, timeout_err} !== '0) begin
      $display("[TB] FAIL reset_values: got ready=%b data=%02h wr=%b grant=%b busy=%b terr=%b, expected all zero",
               req_ready, transmit_data, buffer_write, grant, busy, timeout_err);
    end else passed++;
    @(negedge clk);
    #1 reset = 1'b0;
    msg_q[1].push_back({1'b0, 8'h11});
    msg_q[1].push_back({1'b0, 8'h12});
    msg_q[1].push_back({1'b1, 8'h13});
    wait_grant(20);
    checks++;
    if (grant !== 4'b0010) begin
      $display("[TB] FAIL first_grant_r1: got %b, expected 0010", grant);
    end else passed++;
    #2 reset = 1'b1;
    msg_q[1].delete();
    #1;
    checks++;
    if ({req_ready, transmit_data, buffer_write, grant, busy, timeout_err} !== '0) begin
      $display("[TB] FAIL async_reset_values: got ready=%b data=%02h wr=%b grant=%b busy=%b terr=%b, expected all zero",
               req_ready, transmit_data, buffer_write, grant, busy, timeout_err);
    end else passed++;
    @(negedge clk);
    #1 reset = 1'b0;
    msg_q[0].push_back({1'b1, 8'h41});
    msg_q[1].push_back({1'b1, 8'h42});
    exp_q.push_back(8'h41);
    exp_q.push_back(8'h42);
    wait_grant(20);
    checks++;
    if (grant !== 4'b0001) begin
      $display("[TB] FAIL pointer_after_reset: got grant %b, expected 0001", grant);
    end else passed++;
    wait_drain(100, ok);
    checks++;
    if (!ok) $display("[TB] FAIL reset_drain: got pending traffic, expected idle");
    else passed++;
  endtask

  task automatic test_hi();
    bit ok;
    msg_q[0].push_back({1'b0, 8'h48});
    msg_q[0].push_back({1'b1, 8'h49});
    exp_q.push_back(8'h48);
    exp_q.push_back(8'h49);
    wait_grant(20);
    checks++;
    if (grant !== 4'b0001 || busy !== 1'b1) begin
      $display("[TB] FAIL hi_grant: got grant %b busy %b, expected 0001 1", grant, busy);
    end else passed++;
    wait_drain(100, ok);
    checks++;
    if (!ok) $display("[TB] FAIL hi_drain: got pending traffic, expected idle");
    else passed++;
    checks++;
    if (grant !== 4'b0000 || busy !== 1'b0) begin
      $display("[TB] FAIL hi_release: got grant %b busy %b, expected 0000 0", grant, busy);
    end else passed++;
  endtask

  task automatic test_round();
    bit ok;
    msg_q[3].push_back({1'b1, 8'h30});
    exp_q.push_back(8'h30);
    wait_drain(100, ok);
    checks++;
    if (!ok) $display("[TB] FAIL round_prime_drain: got pending traffic, expected idle");
    else passed++;
    for (int i = 0; i < NUM_REQ; i++) begin
      for (int j = 0; j < 3; j++) begin
        msg_q[i].push_back({(j == 2), 8'(8'h80 + 16 * i + j)});
        exp_q.push_back(8'(8'h80 + 16 * i + j));
      end
    end
    wait_grant(20);
    checks++;
    if (grant !== 4'b0001) begin
      $display("[TB] FAIL round_first_grant: got %b, expected 0001", grant);
    end else passed++;
    wait_drain(300, ok);
    checks++;
    if (!ok) $display("[TB] FAIL round_drain: got pending traffic, expected idle");
    else passed++;
    msg_q[2].push_back({1'b1, 8'hE2});
    msg_q[0].push_back({1'b1, 8'hE0});
    exp_q.push_back(8'hE0);
    exp_q.push_back(8'hE2);
    wait_grant(20);
    checks++;
    if (grant !== 4'b0001) begin
      $display("[TB] FAIL next_round_start: got %b, expected 0001", grant);
    end else passed++;
    wait_drain(100, ok);
    checks++;
    if (!ok) $display("[TB] FAIL next_round_drain: got pending traffic, expected idle");
    else passed++;
  endtask

  task automatic test_full_stall();
    bit ok;
    msg_q[2].push_back({1'b0, 8'h53});
    msg_q[2].push_back({1'b1, 8'h54});
    exp_q.push_back(8'h53);
    exp_q.push_back(8'h54);
    wait_grant(20);
    checks++;
    if (grant !== 4'b0100) begin
      $display("[TB] FAIL stall_grant: got %b, expected 0100", grant);
    end else passed++;
    #1 transmit_full = 1'b1;
    for (int n = 0; n < 20; n++) begin
      @(negedge clk);
      #2;
      checks++;
      if (req_ready !== 4'b0000 || buffer_write !== 1'b0 || grant !== 4'b0100) begin
        $display("[TB] FAIL stall_hold: got ready %b write %b grant %b, expected 0000 0 0100",
                 req_ready, buffer_write, grant);
      end else passed++;
    end
    transmit_full = 1'b0;
    wait_drain(100, ok);
    checks++;
    if (!ok) $display("[TB] FAIL stall_drain: got pending traffic, expected idle");
    else passed++;
  endtask

  task automatic test_alternate();
    bit         ok;
    int         seen;
    logic [3:0] prev;
    logic [3:0] want;
    for (int j = 0; j < 3; j++) begin
      msg_q[1].push_back({1'b1, 8'(8'h61 + j)});
      msg_q[2].push_back({1'b1, 8'(8'h71 + j)});
      exp_q.push_back(8'(8'h61 + j));
      exp_q.push_back(8'(8'h71 + j));
    end
    seen = 0;
    prev = 4'b0000;
    for (int n = 0; n < 80 && seen < 6; n++) begin
      @(negedge clk);
      if (grant !== 4'b0000 && prev === 4'b0000) begin
        want = (seen % 2 == 0) ? 4'b0010 : 4'b0100;
        checks++;
        if (grant !== want) begin
          $display("[TB] FAIL alternate_grant_%0d: got %b, expected %b", seen, grant, want);
        end else passed++;
        seen++;
      end
      prev = grant;
    end
    checks++;
    if (seen != 6) $display("[TB] FAIL alternate_count: got %0d grants, expected 6", seen);
    else passed++;
    wait_drain(100, ok);
    checks++;
    if (!ok) $display("[TB] FAIL alternate_drain: got pending traffic, expected idle");
    else passed++;
  endtask

  task automatic test_timeout();
    bit ok;
    bit found;
    msg_q[3].push_back({1'b0, 8'h91});
    msg_q[0].push_back({1'b1, 8'h0A});
    exp_q.push_back(8'h91);
`ifdef UART_TX_ARB_TIMEOUT_EN
    exp_q.push_back(8'h0A);
`endif
    found = 1'b0;
    for (int n = 0; n < 30; n++) begin
      @(negedge clk);
      if (buffer_write === 1'b1 && transmit_data === 8'h91) begin
        found = 1'b1;
        break;
      end
    end
    checks++;
    if (!found) $display("[TB] FAIL stalled_first_byte: got no write of 8'h91, expected one");
    else passed++;
`ifdef UART_TX_ARB_TIMEOUT_EN
    begin
      logic [3:0] g_at [0:24];
      logic [3:0] nxt;
      int         first_err;
      int         pulses;
      first_err = -1;
      pulses    = 0;
      for (int n = 0; n <= 24; n++) g_at[n] = 4'b0000;
      for (int n = 1; n <= 24; n++) begin
        @(negedge clk);
        g_at[n] = grant;
        if (timeout_err === 1'b1) begin
          pulses++;
          if (first_err < 0) first_err = n;
        end
      end
      checks++;
      if (pulses != 1) $display("[TB] FAIL timeout_pulses: got %0d, expected 1", pulses);
      else passed++;
      checks++;
      if (first_err != 16) $display("[TB] FAIL timeout_latency: got %0d cycles, expected 16", first_err);
      else passed++;
      nxt = (first_err >= 1 && first_err < 24) ? g_at[first_err + 1] : 4'bxxxx;
      checks++;
      if (nxt !== 4'b0001) $display("[TB] FAIL timeout_next_grant: got %b, expected 0001", nxt);
      else passed++;
    end
`else
    begin
      bit held_ok;
      held_ok = 1'b1;
      for (int n = 0; n < 40; n++) begin
        @(negedge clk);
        if (grant !== 4'b1000 || timeout_err !== 1'b0) held_ok = 1'b0;
      end
      checks++;
      if (!held_ok) $display("[TB] FAIL grant_held: got grant %b terr %b, expected 1000 0", grant, timeout_err);
      else passed++;
      msg_q[3].push_back({1'b0, 8'h92});
      msg_q[3].push_back({1'b1, 8'h93});
      exp_q.push_back(8'h92);
      exp_q.push_back(8'h93);
      exp_q.push_back(8'h0A);
    end
`endif
    wait_drain(150, ok);
    checks++;
    if (!ok) $display("[TB] FAIL timeout_drain: got pending traffic, expected idle");
    else passed++;
  endtask

  initial begin
    transmit_full = 1'b0;
    test_reset();
    test_hi();
    test_round();
    test_full_stall();
    test_alternate();
    test_timeout();
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
